// File: rtl/zap_fifo_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFO.
package zap_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/zap_ram_simple_nopipe.sv
// Simple dual-port RAM, one write port and one read port, registered read data
// with a single cycle of latency and no output pipeline stage.
module zap_ram_simple_nopipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/zap_fifo_fwft.sv
// First-word-fall-through FIFO: block RAM storage plus a 2-entry skid buffer
// that absorbs the RAM read latency so the head word comes from a register.
module zap_fifo_fwft
  import zap_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int PW   = ptr_w(DEPTH),
  localparam int AW   = PW - 1,
  localparam int LW   = $clog2(DEPTH + 2) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_valid,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  // Handshake: a push is accepted on a rising edge where i_wr_en=1 and
  // o_full=0; a pop is accepted where i_rd_en=1 and o_valid=1. Anything else
  // on either side is ignored without changing state.

  logic [PW-1:0]    wr_ptr, rd_ptr, ram_count, ram_count_next;
  logic             full_q, rd_pend, skid_head, skid_tail;
  logic [1:0]       skid_cnt;
  logic [2:0]       skid_use;
  logic [WIDTH-1:0] skid_mem [SKID_DEPTH];
  logic [WIDTH-1:0] ram_rd_data;
  logic             push, pop, rd_issue;

  assign ram_count = wr_ptr - rd_ptr;
  assign push      = i_wr_en & ~full_q;
  assign pop       = i_rd_en & (skid_cnt != 2'd0);

  // Occupancy the skid will have once the in-flight word lands and any pop retires.
  assign skid_use  = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_issue  = (ram_count != '0) && (skid_use < 3'(SKID_DEPTH));

  assign ram_count_next = ram_count + PW'(push) - PW'(rd_issue);
  assign skid_tail      = skid_head ^ skid_cnt[0];

  zap_ram_simple_nopipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (i_wr_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      full_q    <= 1'b0;
      rd_pend   <= 1'b0;
      skid_head <= 1'b0;
      skid_cnt  <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_mem[i] <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      rd_pend <= rd_issue;
      full_q  <= (ram_count_next == PW'(DEPTH));
      if (rd_pend) skid_mem[skid_tail] <= ram_rd_data;
      if (pop)     skid_head <= ~skid_head;
      skid_cnt <= skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // Reads only happen from a non-empty RAM and writes never land when full,
  // so read and write can only collide on an address when the RAM is empty.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush)
      assert (!(push && rd_issue && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])) || (ram_count == '0));
  end

  assign o_full    = full_q;
  assign o_valid   = (skid_cnt != 2'd0);
  assign o_rd_data = skid_mem[skid_head];
  assign o_level   = LW'(ram_count) + LW'(rd_pend) + LW'(skid_cnt);
  assign o_empty   = (o_level == '0);

endmodule

// File: tb/tb_zap_fifo_fwft.sv
// Directed and randomized bench for zap_fifo_fwft (WIDTH=8, DEPTH=4) with a
// queue-based reference of the stored words.
module tb_zap_fifo_fwft;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 2) + 1;
  localparam int CAP   = DEPTH + 2;

  logic             clk;
  logic             i_reset, i_flush, i_wr_en, i_rd_en;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_full, o_valid, o_empty;
  logic [WIDTH-1:0] o_rd_data;
  logic [LW-1:0]    o_level;

  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int stall  = 0;
  int seen_valid;

  zap_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_flush   (i_flush),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .o_full    (o_full),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rd_data),
    .o_valid   (o_valid),
    .o_empty   (o_empty),
    .o_level   (o_level)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score the handshake, advance the model.
  task automatic cycle(input logic wr, input logic [WIDTH-1:0] d, input logic rd,
                       input logic fl, input logic rs);
    logic push_ok, pop_ok;
    logic [WIDTH-1:0] front;
    i_wr_en = wr; i_wr_data = d; i_rd_en = rd; i_flush = fl; i_reset = rs;
    push_ok = wr && !o_full;
    pop_ok  = rd && o_valid;
    front   = (exp_q.size() > 0) ? exp_q[0] : 'x;
    if (o_valid) chk("head_data", o_rd_data, front);
    @(posedge clk);
    #1;
    if (rs || fl) exp_q.delete();
    else begin
      if (pop_ok)  void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(d);
    end
    i_wr_en = 1'b0; i_rd_en = 1'b0; i_flush = 1'b0; i_reset = 1'b0;
    chk("level", o_level, exp_q.size());
    chk("empty", o_empty, exp_q.size() == 0);
    chk("level_bound", o_level <= CAP, 1);
    if (o_full) chk("full_implies_ram_full", exp_q.size() >= DEPTH, 1);
    if (exp_q.size() == CAP) chk("full_at_capacity", o_full, 1);
    stall = (exp_q.size() > 0 && !o_valid) ? stall + 1 : 0;
    chk("valid_latency", stall <= 2, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_full"},  o_full, 0);
    chk({tag, "_empty"}, o_empty, 1);
    chk({tag, "_level"}, o_level, 0);
    chk({tag, "_data"},  o_rd_data, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_reset_state("reset");

    // Single word: visible two edges after the push edge.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_level", o_level, 1);
    chk("t1_valid_e0", o_valid, 0);
    idle(1);
    chk("t1_valid_e1", o_valid, 0);
    idle(1);
    chk("t1_valid_e2", o_valid, 1);
    chk("t1_data", o_rd_data, 8'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t1_pop_valid", o_valid, 0);
    chk("t1_pop_empty", o_empty, 1);

    // Fill to capacity, then a dropped push, then drain in order.
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t2_full", o_full, 1);
    chk("t2_level", o_level, 6);
    cycle(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    chk("t2_drop_level", o_level, 6);
    chk("t2_head", o_rd_data, 8'h01);
    drain(10);
    chk("t2_drained", o_empty, 1);

    // Streaming through RAM wrap-around with no bubbles once valid.
    seen_valid = 0;
    for (int i = 0; i < 28; i++) begin
      if (o_valid) seen_valid = 1;
      if (seen_valid && exp_q.size() > 0) chk("t3_no_gap", o_valid, 1);
      cycle(i < 20, 8'(i), 1'b1, 1'b0, 1'b0);
      chk("t3_never_full", o_full, 0);
    end
    chk("t3_drained", o_empty, 1);

    // Flush while a RAM read is in flight, together with a push.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("t4_valid", o_valid, 0);
    chk("t4_level", o_level, 0);
    chk("t4_full", o_full, 0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t4_valid_e1", o_valid, 0);
    idle(1);
    chk("t4_valid_e2", o_valid, 1);
    chk("t4_data", o_rd_data, 8'h55);
    drain(4);

    // Full with simultaneous push and pop: push dropped, pop proceeds.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t5_full", o_full, 1);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("t5_level", o_level, 5);
    chk("t5_full_clear", o_full, 0);
    cycle(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    chk("t5_accept", o_level, 6);
    drain(10);
    chk("t5_drained", o_empty, 1);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t6_level", o_level, 4);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_reset_state("t6");
    idle(3);
    chk("t6_stays_empty", o_valid, 0);
    chk("t6_no_old_data", o_rd_data, 0);

    // Randomized traffic with varying push/pop pressure and rare flushes.
    for (int i = 0; i < 600; i++) begin
      logic wr, rd, fl;
      if (i < 200) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else if (i < 400) begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end else begin
        wr = $urandom_range(0, 1);
        rd = $urandom_range(0, 1);
      end
      fl = ($urandom_range(0, 79) == 0);
      cycle(wr, 8'($urandom_range(0, 255)), rd, fl, 1'b0);
    end
    drain(12);
    chk("final_empty", o_empty, 1);
    chk("final_model_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
